mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Sequencing controller for the MEM stage of the pipelined MIPS datapath when data memory has variable latency. It watches the M-control bits of the instruction held in EX/MEM and issues a req/ready handshake to data memory. While the access is outstanding it freezes the upstream pipeline registers and forces a bubble into MEM/WB. It holds the returned read data so the MEM/WB register captures it in the release cycle, and it flags a sticky error if memory never answers.

Parameters:
TIMEOUT, 15, max cycles spent in WAIT before declaring a memory fault (1 .. 2^CNT_W-1)
CNT_W, 4, width of wait counter and latency report

Ports:
clk  in  1  pipeline clock; controller state updates on negedge clk, same edge as the pipeline registers
rst  in  1  asynchronous, active-low reset (rst=0 resets)
mem_read_i  in  1  EX/MEM MemRead bit of instruction in MEM stage
mem_write_i  in  1  EX/MEM MemWrite bit of instruction in MEM stage
mem_ready_i  in  1  data memory completion strobe, sampled in WAIT only
mem_rdata_i  in  32  data memory read data, valid when mem_ready_i=1
mem_req_o  out  1  registered request to data memory, held high for whole access
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
bubble_o  out  1  force MEM/WB WB bits to 2'b00 this cycle
rdata_o  out  32  held read data presented to MEM/WB memory_Output input
rdata_valid_o  out  1  one-cycle pulse, rdata_o/write completion usable
last_latency_o  out  CNT_W  WAIT-cycle count of last completed access
err_o  out  1  sticky timeout flag

Behaviour:
- access = mem_read_i | mem_write_i. If both are 1, treat as a read.
- States: IDLE, WAIT, DONE, ERR. Encoding is free.
- Reset (rst=0, async): state=IDLE; mem_req_o=0; cnt=0; rdata_o=0; last_latency_o=0; err_o=0. Outputs are valid immediately, not at the next edge.
- Reset asserted mid-access drops mem_req_o at once and abandons the access. Memory tolerates a dropped request.
- IDLE:
  - mem_req_o=0, rdata_valid_o=0.
  - stall_o = bubble_o = access (combinational), so the instruction is held in EX/MEM from its first MEM cycle.
  - If access: next state WAIT; mem_req_o<=1; cnt<=0.
- WAIT:
  - stall_o=1, bubble_o=1, mem_req_o=1.
  - If mem_ready_i: rdata_o<=mem_rdata_i (reads only; writes leave rdata_o unchanged); last_latency_o<=cnt; mem_req_o<=0; next state DONE.
  - Else if cnt==TIMEOUT-1: err_o<=1; mem_req_o<=0; next state ERR.
  - Else cnt<=cnt+1. The counter never wraps.
  - mem_ready_i and timeout in the same cycle: ready wins.
- DONE:
  - stall_o=0, bubble_o=0, rdata_valid_o=1, mem_req_o=0.
  - Pipeline advances on this edge and MEM/WB captures rdata_o.
  - access is ignored here, because it still belongs to the completed instruction.
  - Next state IDLE unconditionally.
- ERR:
  - stall_o=1, bubble_o=1, mem_req_o=0, err_o=1.
  - Stays in ERR until rst. mem_ready_i is ignored.
- Back-to-back memory instructions: each access costs its WAIT cycles plus 1 IDLE cycle plus 1 DONE cycle. Minimum with immediate ready is 3 cycles per access.
- Non-memory instructions in IDLE pass with zero overhead: stall_o=0, bubble_o=0.
- mem_ready_i outside WAIT has no effect.
- rdata_o holds its value until the next read completes.

Test Plan:
- Reset: drive rst=0 asynchronously mid-WAIT -> mem_req_o, stall_o, err_o, rdata_o, last_latency_o all read 0 before the next clock edge; state returns to IDLE.
- Single read, ready after 3 WAIT cycles with mem_rdata_i=32'hDEADBEEF -> stall_o high 4 cycles (IDLE+3 WAIT); then DONE with rdata_o=DEADBEEF, rdata_valid_o 1 cycle, last_latency_o=2.
- Write with ready on first WAIT cycle -> last_latency_o=0; rdata_o unchanged from previous read; stall_o low in DONE.
- No ready for TIMEOUT=15 cycles -> err_o=1 after the 15th WAIT cycle; mem_req_o=0; stall_o stays 1 indefinitely; a later mem_ready_i pulse is ignored.
- Ready arriving in the same cycle as cnt==14 -> DONE taken, err_o stays 0, last_latency_o=14.
- Sequence lw, add, sw, lw with ready after 1 cycle each -> add causes no stall; every access shows exactly one bubble_o per stalled cycle; MEM/WB WB bits are 0 during bubbles and correct in each DONE cycle.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Handshake and pipeline-control bundle between the MEM-stage controller,
// the EX/MEM control bits, data memory and the MEM/WB register.
interface mem_stage_ctrl_if #(
    parameter int CNT_W = 4
);
    logic              mem_read_i;
    logic              mem_write_i;
    logic              mem_ready_i;
    logic [31:0]       mem_rdata_i;

    logic              mem_req_o;
    logic              stall_o;
    logic              bubble_o;
    logic [31:0]       rdata_o;
    logic              rdata_valid_o;
    logic [CNT_W-1:0]  last_latency_o;
    logic              err_o;

    // Controller side
    modport master (
        input  mem_read_i, mem_write_i, mem_ready_i, mem_rdata_i,
        output mem_req_o, stall_o, bubble_o, rdata_o, rdata_valid_o,
               last_latency_o, err_o
    );

    // Pipeline / memory side
    modport slave (
        output mem_read_i, mem_write_i, mem_ready_i, mem_rdata_i,
        input  mem_req_o, stall_o, bubble_o, rdata_o, rdata_valid_o,
               last_latency_o, err_o
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer for variable-latency data memory: issues req/ready,
// freezes the upstream pipeline, bubbles MEM/WB and holds returned read data.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_stage_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  lat_reg, lat_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic              req_reg, req_next;
    logic              err_reg, err_next;
    logic              is_read_reg, is_read_next;

    logic              access;
    logic              stall_c;
    logic              valid_c;

    assign access = bus.mem_read_i | bus.mem_write_i;

    // State advances on the same (falling) edge as the pipeline registers.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            lat_reg     <= '0;
            rdata_reg   <= '0;
            req_reg     <= 1'b0;
            err_reg     <= 1'b0;
            is_read_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            lat_reg     <= lat_next;
            rdata_reg   <= rdata_next;
            req_reg     <= req_next;
            err_reg     <= err_next;
            is_read_reg <= is_read_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        lat_next     = lat_reg;
        rdata_next   = rdata_reg;
        req_next     = req_reg;
        err_next     = err_reg;
        is_read_next = is_read_reg;
        stall_c      = 1'b0;
        valid_c      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                stall_c = access;
                if (access) begin
                    state_next   = ST_WAIT;
                    req_next     = 1'b1;
                    cnt_next     = '0;
                    // Read wins when both control bits are set.
                    is_read_next = bus.mem_read_i;
                end
            end

            ST_WAIT: begin
                stall_c = 1'b1;
                if (bus.mem_ready_i) begin
                    if (is_read_reg) begin
                        rdata_next = bus.mem_rdata_i;
                    end
                    lat_next   = cnt_reg;
                    req_next   = 1'b0;
                    state_next = ST_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    req_next   = 1'b0;
                    state_next = ST_ERR;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_DONE: begin
                // Access bits still belong to the retiring instruction.
                valid_c    = 1'b1;
                state_next = ST_IDLE;
            end

            ST_ERR: begin
                stall_c = 1'b1;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Gate with rst so the pipeline is not held frozen while reset is asserted.
    assign bus.stall_o        = rst & stall_c;
    assign bus.bubble_o       = rst & stall_c;
    assign bus.rdata_valid_o  = rst & valid_c;
    assign bus.mem_req_o      = req_reg;
    assign bus.rdata_o        = rdata_reg;
    assign bus.last_latency_o = lat_reg;
    assign bus.err_o          = err_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench: per-instruction timelines derived from ready delays,
// compared every cycle against the controller outputs.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_stage_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mem_stage_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: what the visible registers must hold this cycle (m_*)
    // and what they will hold once the next falling edge has passed (p_*).
    logic [31:0]      m_rdata = '0, p_rdata = '0;
    logic [CNT_W-1:0] m_lat   = '0, p_lat   = '0;
    logic             m_err   = 1'b0, p_err = 1'b0;
    logic             exp_stall = 1'b0, exp_req = 1'b0, exp_valid = 1'b0;
    bit               chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Outputs are sampled on the rising edge, half a cycle from the update edge.
    always @(posedge clk) begin
        if (chk_en) begin
            check("stall",   32'(bus.stall_o),        32'(exp_stall));
            check("bubble",  32'(bus.bubble_o),       32'(exp_stall));
            check("req",     32'(bus.mem_req_o),      32'(exp_req));
            check("valid",   32'(bus.rdata_valid_o),  32'(exp_valid));
            check("rdata",   bus.rdata_o,             m_rdata);
            check("latency", 32'(bus.last_latency_o), 32'(m_lat));
            check("err",     32'(bus.err_o),          32'(m_err));
        end
    end

    task automatic drive(input bit rd, input bit wr, input bit rdy, input logic [31:0] data,
                         input bit e_stall, input bit e_req, input bit e_valid);
        @(negedge clk);
        #1;
        bus.mem_read_i  = rd;
        bus.mem_write_i = wr;
        bus.mem_ready_i = rdy;
        bus.mem_rdata_i = data;
        exp_stall = e_stall;
        exp_req   = e_req;
        exp_valid = e_valid;
        m_rdata   = p_rdata;
        m_lat     = p_lat;
        m_err     = p_err;
        chk_en    = 1'b1;
    endtask

    task automatic do_nonmem();
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b0);
    endtask

    // d < TIMEOUT: ready arrives in WAIT cycle d. d >= TIMEOUT: memory never answers.
    task automatic do_mem(input bit rd, input bit wr, input int d, input logic [31:0] data);
        int nw;
        bit rdy;
        nw = (d < TIMEOUT) ? d + 1 : TIMEOUT;
        $display("instr rd=%0d wr=%0d delay=%0d data=%h", rd, wr, d, data);
        drive(rd, wr, 1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < nw; j++) begin
            rdy = (d < TIMEOUT) && (j == d);
            drive(rd, wr, rdy, rdy ? data : $urandom, 1'b1, 1'b1, 1'b0);
        end
        if (d < TIMEOUT) begin
            if (rd) p_rdata = data;
            p_lat = CNT_W'(d);
            drive(rd, wr, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b1);
        end else begin
            p_err = 1'b1;
            for (int k = 0; k < 6; k++)
                drive(rd, wr, (k == 2) ? 1'b1 : 1'($urandom_range(0, 1)), data,
                      1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},     32'(bus.mem_req_o),      32'd0);
        check({tag, "_stall"},   32'(bus.stall_o),        32'd0);
        check({tag, "_bubble"},  32'(bus.bubble_o),       32'd0);
        check({tag, "_valid"},   32'(bus.rdata_valid_o),  32'd0);
        check({tag, "_err"},     32'(bus.err_o),          32'd0);
        check({tag, "_rdata"},   bus.rdata_o,             32'd0);
        check({tag, "_latency"}, 32'(bus.last_latency_o), 32'd0);
    endtask

    // Assert reset between edges, check outputs at once, then release cleanly.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst    = 1'b0;
        #1;
        $display("reset %s asserted mid-cycle", tag);
        check_reset_outputs(tag);
        bus.mem_read_i  = 1'b0;
        bus.mem_write_i = 1'b0;
        bus.mem_ready_i = 1'b0;
        p_rdata = '0;
        p_lat   = '0;
        p_err   = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int d;
        // Access bits held high during reset: stall must still stay low.
        bus.mem_read_i  = 1'b1;
        bus.mem_write_i = 1'b0;
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'hFFFF_FFFF;
        #2;
        check_reset_outputs("por");
        bus.mem_read_i  = 1'b0;
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Directed read, ready in third WAIT cycle.
        do_mem(1'b1, 1'b0, 2, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("lit_rd_rdata",   bus.rdata_o,             32'hDEAD_BEEF);
        check("lit_rd_latency", 32'(bus.last_latency_o), 32'd2);
        check("lit_rd_valid",   32'(bus.rdata_valid_o),  32'd1);

        // Write with immediate ready leaves read data untouched.
        do_mem(1'b0, 1'b1, 0, 32'h0BAD_F00D);
        @(posedge clk);
        #1;
        check("lit_wr_rdata",   bus.rdata_o,             32'hDEAD_BEEF);
        check("lit_wr_latency", 32'(bus.last_latency_o), 32'd0);
        check("lit_wr_stall",   32'(bus.stall_o),        32'd0);

        // Ready coincides with the last allowed WAIT cycle.
        do_mem(1'b1, 1'b0, TIMEOUT - 1, 32'h1234_5678);
        @(posedge clk);
        #1;
        check("lit_edge_latency", 32'(bus.last_latency_o), 32'd14);
        check("lit_edge_err",     32'(bus.err_o),          32'd0);

        // lw, add, sw, lw
        do_mem(1'b1, 1'b0, 1, 32'hA5A5_0001);
        do_nonmem();
        do_mem(1'b0, 1'b1, 1, 32'h5A5A_0002);
        do_mem(1'b1, 1'b0, 1, 32'hC3C3_0003);

        // Reset in the middle of a WAIT.
        drive(1'b1, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, $urandom, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, $urandom, 1'b1, 1'b1, 1'b0);
        async_reset("midwait");

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            d    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TIMEOUT - 1)
                                               : $urandom_range(0, 3);
            case (kind)
                0: do_nonmem();
                1: do_mem(1'b1, 1'b0, d, $urandom);
                2: do_mem(1'b0, 1'b1, d, $urandom);
                default: do_mem(1'b1, 1'b1, d, $urandom);
            endcase
        end

        // Memory never answers: sticky error, late ready ignored.
        do_mem(1'b1, 1'b0, TIMEOUT, 32'h7777_7777);
        @(posedge clk);
        #1;
        check("lit_to_err",   32'(bus.err_o),     32'd1);
        check("lit_to_req",   32'(bus.mem_req_o), 32'd0);
        check("lit_to_stall", 32'(bus.stall_o),   32'd1);

        async_reset("fromerr");
        do_mem(1'b1, 1'b0, 0, 32'hFEED_FACE);
        do_nonmem();

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
